// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard controller: stalls, bubbles, MDU wait FSM, watchdog, stall counter
//
// Purpose: drives the enable/flush controls of the PC and the IF/ID, ID/EX,
// EX/MEM and MEM/WB pipeline registers. Handles data-memory stalls, multi-cycle
// MDU ops, EX-stage redirects and load-use hazards, in that priority order.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   id_rs1, id_rs2             ID-stage source register indices
//   id_use_rs1, id_use_rs2     ID instruction actually reads rs1 / rs2
//   ex_rd, ex_is_load          EX-stage destination register and load flag
//   ex_redirect                EX resolved a taken branch/jump or mispredict
//   ex_mdu_valid, mdu_done     MDU op in EX / MDU result valid this cycle
//   mem_stall                  data memory not ready, freeze everything
//   *_en, *_flush              stage register enables and bubble clears
//   stall_cycles               saturating count of cycles with pc_en=0
//   mdu_fault                  sticky MDU watchdog error
module hazard_ctrl #(
  parameter int REG_W       = 5,
  parameter int MDU_TIMEOUT = 64,
  parameter int PERF_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_W-1:0]  id_rs1,
  input  logic [REG_W-1:0]  id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_W-1:0]  ex_rd,
  input  logic              ex_is_load,
  input  logic              ex_redirect,
  input  logic              ex_mdu_valid,
  input  logic              mdu_done,
  input  logic              mem_stall,
  output logic              pc_en,
  output logic              ifid_en,
  output logic              idex_en,
  output logic              exmem_en,
  output logic              memwb_en,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic              exmem_flush,
  output logic              memwb_flush,
  output logic [PERF_W-1:0] stall_cycles,
  output logic              mdu_fault
);

  localparam int WD_W = (MDU_TIMEOUT > 1) ? $clog2(MDU_TIMEOUT) : 1;

  typedef enum logic {
    RUN      = 1'b0,
    MDU_WAIT = 1'b1
  } state_t;

  state_t              state_q;
  logic [WD_W-1:0]     wd_cnt_q;
  logic [PERF_W-1:0]   stall_cycles_q;
  logic [PERF_W-1:0]   stall_cycles_d;
  logic                mdu_fault_q;
  // Set for the RUN cycle that follows a watchdog abort, so the stuck MDU
  // instruction is let through instead of restarting the wait.
  logic                wd_release_q;

  logic                load_use;
  logic                mdu_stall;
  logic                wd_expire;

  always_comb begin
    load_use = ex_is_load && (ex_rd != '0) &&
               ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                (id_use_rs2 && (id_rs2 == ex_rd)));

    if (state_q == MDU_WAIT) begin
      mdu_stall = !mdu_done;
    end else begin
      mdu_stall = ex_mdu_valid && !mdu_done && !wd_release_q;
    end

    wd_expire = (state_q == MDU_WAIT) && !mdu_done &&
                (wd_cnt_q == WD_W'(MDU_TIMEOUT - 1));
  end

  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    memwb_en    = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    memwb_flush = 1'b0;

    if (reset) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_en    = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      memwb_flush = 1'b1;
    end else if (mem_stall) begin
      // Whole pipe frozen; WB gets a bubble so a retired instr is not re-written.
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_en    = 1'b0;
      memwb_flush = 1'b1;
    end else if (mdu_stall) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_flush = 1'b1;
    end else if (ex_redirect) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
    end else if (load_use) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_flush  = 1'b1;
    end
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (!pc_en && (stall_cycles_q != '1)) begin
      stall_cycles_d = stall_cycles_q + PERF_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= RUN;
      wd_cnt_q       <= '0;
      stall_cycles_q <= '0;
      mdu_fault_q    <= 1'b0;
      wd_release_q   <= 1'b0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      // mem_stall freezes the FSM so an MDU op in EX is re-evaluated next cycle.
      if (!mem_stall) begin
        case (state_q)
          RUN: begin
            wd_cnt_q <= '0;
            if (wd_release_q) begin
              wd_release_q <= 1'b0;
            end else if (ex_mdu_valid && !mdu_done) begin
              state_q <= MDU_WAIT;
            end
          end
          MDU_WAIT: begin
            if (mdu_done) begin
              state_q  <= RUN;
              wd_cnt_q <= '0;
            end else if (wd_expire) begin
              state_q      <= RUN;
              wd_cnt_q     <= '0;
              mdu_fault_q  <= 1'b1;
              wd_release_q <= 1'b1;
            end else begin
              wd_cnt_q <= wd_cnt_q + WD_W'(1);
            end
          end
          default: begin
            state_q  <= RUN;
            wd_cnt_q <= '0;
          end
        endcase
      end
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign mdu_fault    = mdu_fault_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

  // Control vector order: pc, ifid, idex, exmem, memwb en | ifid, idex, exmem, memwb flush
  localparam logic [8:0] P_RUN   = 9'b11111_0000;
  localparam logic [8:0] P_RESET = 9'b00000_1111;
  localparam logic [8:0] P_MEM   = 9'b00000_0001;
  localparam logic [8:0] P_MDU   = 9'b00011_0010;
  localparam logic [8:0] P_REDIR = 9'b11111_1100;
  localparam logic [8:0] P_LDUSE = 9'b00111_0100;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_use_rs1, id_use_rs2, ex_is_load, ex_redirect;
  logic       ex_mdu_valid, mdu_done, mem_stall;

  logic [8:0]  ctl_a, ctl_b;
  logic [31:0] stall_a;
  logic [3:0]  stall_b;
  logic        fault_a, fault_b;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hazard_ctrl dut_a (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_redirect(ex_redirect),
    .ex_mdu_valid(ex_mdu_valid), .mdu_done(mdu_done), .mem_stall(mem_stall),
    .pc_en(ctl_a[8]), .ifid_en(ctl_a[7]), .idex_en(ctl_a[6]), .exmem_en(ctl_a[5]), .memwb_en(ctl_a[4]),
    .ifid_flush(ctl_a[3]), .idex_flush(ctl_a[2]), .exmem_flush(ctl_a[1]), .memwb_flush(ctl_a[0]),
    .stall_cycles(stall_a), .mdu_fault(fault_a)
  );

  hazard_ctrl #(.REG_W(5), .MDU_TIMEOUT(4), .PERF_W(4)) dut_b (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_redirect(ex_redirect),
    .ex_mdu_valid(ex_mdu_valid), .mdu_done(mdu_done), .mem_stall(mem_stall),
    .pc_en(ctl_b[8]), .ifid_en(ctl_b[7]), .idex_en(ctl_b[6]), .exmem_en(ctl_b[5]), .memwb_en(ctl_b[4]),
    .ifid_flush(ctl_b[3]), .idex_flush(ctl_b[2]), .exmem_flush(ctl_b[1]), .memwb_flush(ctl_b[0]),
    .stall_cycles(stall_b), .mdu_fault(fault_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next negedge (one posedge passes); inputs then change and settle.
  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
    id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; ex_is_load = 1'b0; ex_redirect = 1'b0;
    ex_mdu_valid = 1'b0; mdu_done = 1'b0; mem_stall = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    next_cycle();
    #1;
    chk("reset_ctl_a", 32'(ctl_a), 32'(P_RESET));
    next_cycle();
    reset = 1'b0;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    reset = 1'b1;
    idle_inputs();
    do_reset();
    chk("reset_stall_a", stall_a, 32'd0);
    chk("reset_fault_a", 32'(fault_a), 32'd0);
    chk("idle_ctl_a", 32'(ctl_a), 32'(P_RUN));

    // lw x5 in EX, ID reads x5 through rs2
    next_cycle();
    ex_is_load = 1'b1; ex_rd = 5'd5;
    id_use_rs1 = 1'b1; id_rs1 = 5'd3; id_use_rs2 = 1'b1; id_rs2 = 5'd5;
    #1 chk("lduse_rs2", 32'(ctl_a), 32'(P_LDUSE));
    next_cycle();
    ex_is_load = 1'b0; ex_rd = 5'd0;
    #1 chk("lduse_after", 32'(ctl_a), 32'(P_RUN));
    chk("lduse_stall_cnt", stall_a, 32'd1);

    // lw x0 never creates a hazard
    next_cycle();
    ex_is_load = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_use_rs1 = 1'b1;
    #1 chk("lduse_x0", 32'(ctl_a), 32'(P_RUN));

    // load-use via rs1 with a simultaneous redirect: redirect wins
    next_cycle();
    ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs2 = 1'b0; ex_redirect = 1'b1;
    #1 chk("lduse_redirect", 32'(ctl_a), 32'(P_REDIR));
    next_cycle();
    ex_redirect = 1'b0;
    #1 chk("lduse_rs1", 32'(ctl_a), 32'(P_LDUSE));

    // rs1 matches but is not read: no hazard
    next_cycle();
    id_use_rs1 = 1'b0;
    #1 chk("lduse_unused", 32'(ctl_a), 32'(P_RUN));

    // MDU op finishing on the sixth cycle: five stalls then release
    do_reset();
    ex_mdu_valid = 1'b1; mdu_done = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1 chk($sformatf("mdu_wait_%0d", i), 32'(ctl_a), 32'(P_MDU));
      next_cycle();
    end
    mdu_done = 1'b1;
    #1 chk("mdu_done", 32'(ctl_a), 32'(P_RUN));
    chk("mdu_stall_cnt", stall_a, 32'd5);
    next_cycle();
    ex_mdu_valid = 1'b0; mdu_done = 1'b0;
    #1 chk("mdu_back_run", 32'(ctl_a), 32'(P_RUN));
    chk("mdu_no_fault", 32'(fault_a), 32'd0);

    // mem_stall over a pending redirect: redirect re-presented afterwards
    ex_redirect = 1'b1; mem_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk($sformatf("memstall_%0d", i), 32'(ctl_a), 32'(P_MEM));
      next_cycle();
    end
    mem_stall = 1'b0;
    #1 chk("memstall_redirect", 32'(ctl_a), 32'(P_REDIR));
    chk("memstall_cnt", stall_a, 32'd8);
    next_cycle();
    ex_redirect = 1'b0;

    // Watchdog on dut_b (MDU_TIMEOUT=4): one RUN stall plus four MDU_WAIT stalls
    do_reset();
    ex_mdu_valid = 1'b1; mdu_done = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1 chk($sformatf("wd_stall_%0d", i), 32'(ctl_b), 32'(P_MDU));
      chk($sformatf("wd_fault_pre_%0d", i), 32'(fault_b), 32'd0);
      next_cycle();
    end
    #1 chk("wd_release", 32'(ctl_b), 32'(P_RUN));
    chk("wd_fault", 32'(fault_b), 32'd1);
    chk("wd_stall_cnt", 32'(stall_b), 32'd5);
    next_cycle();
    ex_mdu_valid = 1'b0;
    #1 chk("wd_after_run", 32'(ctl_b), 32'(P_RUN));

    // Saturation of the 4-bit counter with a held load-use stall
    ex_is_load = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7; id_use_rs2 = 1'b1;
    for (int i = 0; i < 9; i++) next_cycle();
    #1 chk("sat_14", 32'(stall_b), 32'd14);
    for (int i = 0; i < 11; i++) next_cycle();
    #1 chk("sat_15", 32'(stall_b), 32'd15);
    chk("sat_ctl", 32'(ctl_b), 32'(P_LDUSE));
    chk("fault_sticky", 32'(fault_b), 32'd1);
    idle_inputs();

    // Reset while dut_b sits in MDU_WAIT
    ex_mdu_valid = 1'b1;
    next_cycle();
    next_cycle();
    #1 chk("pre_reset_wait", 32'(ctl_b), 32'(P_MDU));
    ex_mdu_valid = 1'b0;
    #1 chk("wait_ignores_valid", 32'(ctl_b), 32'(P_MDU));
    do_reset();
    chk("post_reset_run", 32'(ctl_b), 32'(P_RUN));
    chk("post_reset_cnt", 32'(stall_b), 32'd0);
    chk("post_reset_fault", 32'(fault_b), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
